dsk_prefetch: RTL and testbench

Disk-image read client for the floppy emulation path. It owns one disk read slot (`dskReadAddrInt`/`dskReadAckInt` or the Ext pair) of the address controller's extra bus cycle. It fetches consecutive 16-bit words of the disk image from RAM into a small FIFO and serves them to the floppy/IWM emulation as a big-endian byte stream. It sits directly upstream of the address controller: it supplies the image-relative read address and consumes the acknowledge and RAM read data.

---
 rtl/dsk_pkg.sv | 21 ++
 rtl/dsk_word_fifo.sv | 82 ++++++++
 rtl/dsk_prefetch.sv | 94 +++++++++
 tb/tb_dsk_prefetch.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dsk_pkg.sv
// Shared definitions for the disk-image read path: address width, word step
// and the image base offsets used by both the prefetcher and the address controller.
package dsk_pkg;

  localparam int          DSK_ADDR_W    = 22;
  localparam logic [21:0] DSK_ADDR_STEP = 22'd2;
  localparam logic [21:0] DSK_BASE_INT  = 22'h100000;
  localparam logic [21:0] DSK_BASE_EXT  = 22'h200000;

  typedef logic [DSK_ADDR_W-1:0] dsk_addr_t;

  // Word step; the natural 22-bit overflow gives the 3FFFFE -> 000000 wrap.
  function automatic dsk_addr_t dsk_next_addr(input dsk_addr_t a);
    return a + DSK_ADDR_STEP;
  endfunction

  function automatic dsk_addr_t dsk_align(input dsk_addr_t a);
    return {a[DSK_ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/dsk_word_fifo.sv
// 16-bit synchronous word FIFO with occupancy count, flush and async reset.
// Fullness gates the push before any same-edge pop is considered.
module dsk_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [15:0]                  wdata_i,
  output logic [15:0]                  head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s, empty_s, do_push_s, do_pop_s;

  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign empty_s   = (count_q == CNT_W'(0));
  assign do_push_s = push_i && !full_s && !flush_i;
  assign do_pop_s  = pop_i && !empty_s && !flush_i;

  // Next-state pointers and count.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = PTR_W'(0);
      rd_d    = PTR_W'(0);
      count_d = CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_d = wr_q + PTR_W'(1);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = rd_q + PTR_W'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= PTR_W'(0);
      rd_q    <= PTR_W'(0);
      count_q <= CNT_W'(0);
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Word storage; contents only matter while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = full_s;

endmodule

// File: rtl/dsk_prefetch.sv
// Disk-image prefetcher: fills a word FIFO from this client's RAM slot and
// serves the words as a big-endian byte stream; seek restarts the stream.
module dsk_prefetch
  import dsk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dskReadAck,
  input  logic                  memoryLatch,
  input  logic [15:0]           memDataIn,
  output logic [DSK_ADDR_W-1:0] dskReadAddr,
  input  logic                  seek,
  input  logic [DSK_ADDR_W-1:0] seekAddr,
  input  logic                  byteReq,
  output logic [7:0]            byteOut,
  output logic                  byteValid
);

  localparam int CNT_W = $clog2(DEPTH+1);

  dsk_addr_t        addr_q, addr_d;
  logic             ph_q, ph_d;
  logic [15:0]      head_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s, valid_s, latch_s, push_s, take_s, pop_s;

  assign valid_s = (count_s != CNT_W'(0));
  assign latch_s = dskReadAck && memoryLatch && !seek;
  assign push_s  = latch_s && !full_s;
  assign take_s  = byteReq && valid_s && !seek;
  assign pop_s   = take_s && ph_q;

  dsk_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (seek),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (memDataIn),
    .head_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s)
  );

  // Fetch address and byte phase; seek overrides both.
  always_comb begin
    addr_d = addr_q;
    ph_d   = ph_q;
    if (seek) begin
      addr_d = dsk_align(seekAddr);
      ph_d   = 1'b0;
    end else begin
      if (push_s) begin
        addr_d = dsk_next_addr(addr_q);
      end else begin
        addr_d = addr_q;
      end
      if (take_s) begin
        ph_d = ~ph_q;
      end else begin
        ph_d = ph_q;
      end
    end
  end

  // Address and phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= 22'h000000;
      ph_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ph_q   <= ph_d;
    end
  end

  // Byte decode from registered state only.
  always_comb begin
    byteOut = 8'h00;
    if (!valid_s) begin
      byteOut = 8'h00;
    end else if (ph_q) begin
      byteOut = head_s[7:0];
    end else begin
      byteOut = head_s[15:8];
    end
  end

  assign byteValid   = valid_s;
  assign dskReadAddr = addr_q;

endmodule

// File: tb/tb_dsk_prefetch.sv
// Directed self-checking bench for dsk_prefetch (DEPTH=4) with hand-computed
// addresses and byte streams.
module tb_dsk_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dskReadAck = 1'b0;
  logic        memoryLatch = 1'b0;
  logic [15:0] memDataIn = 16'h0000;
  logic [21:0] dskReadAddr;
  logic        seek = 1'b0;
  logic [21:0] seekAddr = 22'h000000;
  logic        byteReq = 1'b0;
  logic [7:0]  byteOut;
  logic        byteValid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsk_prefetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .dskReadAck  (dskReadAck),
    .memoryLatch (memoryLatch),
    .memDataIn   (memDataIn),
    .dskReadAddr (dskReadAddr),
    .seek        (seek),
    .seekAddr    (seekAddr),
    .byteReq     (byteReq),
    .byteOut     (byteOut),
    .byteValid   (byteValid)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [21:0] a, input logic v, input logic [7:0] b);
    check_val({tag, ".addr"}, 32'(dskReadAddr), 32'(a));
    check_val({tag, ".valid"}, 32'(byteValid), 32'(v));
    check_val({tag, ".byte"}, 32'(byteOut), 32'(b));
  endtask

  // One 4-clk bus cycle; optional seek (and byteReq) on cycle sk_cyc.
  task automatic run_slot(input logic [15:0] d, input int sk_cyc, input logic [21:0] sa, input logic rq);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dskReadAck  = 1'b1;
      memoryLatch = (i == 3);
      memDataIn   = d;
      seek        = (i == sk_cyc);
      seekAddr    = sa;
      byteReq     = (i == sk_cyc) && rq;
    end
    @(negedge clk);
    dskReadAck  = 1'b0;
    memoryLatch = 1'b0;
    memDataIn   = 16'h0000;
    seek        = 1'b0;
    byteReq     = 1'b0;
  endtask

  task automatic slot(input logic [15:0] d);
    run_slot(d, -1, 22'h000000, 1'b0);
  endtask

  task automatic do_seek(input logic [21:0] a);
    @(negedge clk);
    seek = 1'b1;
    seekAddr = a;
    @(negedge clk);
    seek = 1'b0;
  endtask

  task automatic req;
    @(negedge clk);
    byteReq = 1'b1;
    @(negedge clk);
    byteReq = 1'b0;
  endtask

  logic [7:0] drain_exp [8] = '{8'hA2, 8'hB2, 8'hA3, 8'hB3, 8'hA4, 8'hB4, 8'hA7, 8'hB7};
  logic [21:0] fill_addr [6] = '{22'h2, 22'h4, 22'h6, 22'h8, 22'h8, 22'h8};

  initial begin
    // Reset then idle with no ack.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check_out("idle", 22'h0, 1'b0, 8'h00);
    end

    // Seek to odd offset, two words, read out four bytes.
    do_seek(22'h000401);
    check_val("seek401.addr", 32'(dskReadAddr), 32'h400);
    slot(16'hA55A);
    check_out("w0", 22'h402, 1'b1, 8'hA5);
    slot(16'h1234);
    check_val("w1.addr", 32'(dskReadAddr), 32'h404);
    req(); check_out("b1", 22'h404, 1'b1, 8'h5A);
    req(); check_out("b2", 22'h404, 1'b1, 8'h12);
    req(); check_out("b3", 22'h404, 1'b1, 8'h34);
    req(); check_out("b4", 22'h404, 1'b0, 8'h00);

    // Six slots with no consumer: four pushes, then the address holds.
    do_seek(22'h000000);
    for (int k = 0; k < 6; k++) begin
      slot(16'hA1B1 + 16'(k) * 16'h0101);
      check_val("fill.addr", 32'(dskReadAddr), 32'(fill_addr[k]));
    end
    check_out("full", 22'h8, 1'b1, 8'hA1);
    req(); check_val("full.b1", 32'(byteOut), 32'hB1);
    req(); check_val("full.b2", 32'(byteOut), 32'hA2);
    slot(16'hA7B7);
    check_val("resume.addr", 32'(dskReadAddr), 32'h00A);
    check_val("drain.b0", 32'(byteOut), 32'(drain_exp[0]));
    for (int k = 1; k < 8; k++) begin
      req();
      check_val("drain", 32'(byteOut), 32'(drain_exp[k]));
    end
    req();
    check_out("drained", 22'h00A, 1'b0, 8'h00);

    // Address wrap at the top of the image space.
    do_seek(22'h3FFFFE);
    check_val("wrap.a0", 32'(dskReadAddr), 32'h3FFFFE);
    slot(16'h1111);
    check_val("wrap.a1", 32'(dskReadAddr), 32'h000000);
    slot(16'h2222);
    check_val("wrap.a2", 32'(dskReadAddr), 32'h000002);

    // Seek coincident with latch and byteReq, two words buffered, ph=1.
    do_seek(22'h000100);
    slot(16'hBEEF);
    slot(16'hCAFE);
    check_val("pre.addr", 32'(dskReadAddr), 32'h104);
    req();
    check_val("pre.ph1", 32'(byteOut), 32'hEF);
    run_slot(16'hDEAD, 3, 22'h002001, 1'b1);
    check_out("seeklatch", 22'h2000, 1'b0, 8'h00);
    slot(16'h1357);
    check_out("postseek", 22'h2002, 1'b1, 8'h13);

    // Seek mid-slot: the same slot's latch fetches from the new address.
    run_slot(16'h9A9B, 1, 22'h003000, 1'b0);
    check_out("midslot", 22'h3002, 1'b1, 8'h9A);
    req(); check_val("midslot.b1", 32'(byteOut), 32'h9B);
    req(); check_val("midslot.empty", 32'(byteValid), 32'h0);

    // Asynchronous reset mid-slot with three words buffered.
    do_seek(22'h000000);
    slot(16'h0102);
    slot(16'h0304);
    slot(16'h0506);
    check_out("prereset", 22'h6, 1'b1, 8'h01);
    @(negedge clk);
    dskReadAck = 1'b1;
    #2 reset = 1'b1;
    #1 check_out("asyncrst", 22'h0, 1'b0, 8'h00);
    @(negedge clk);
    dskReadAck = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_out("afterrst", 22'h0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
